// File: rtl/iot_event_serializer.sv
// Per-device on/off transition detector and round-robin event serializer feeding a up/down monitor.
// Optional input debouncing is enabled by defining DEBOUNCE_EN (DEB_CYCLES stable cycles per level).
module iot_event_serializer #(
  parameter int N_DEV      = 8,
  parameter int ID_W       = $clog2(N_DEV),
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_DEV-1:0]  dev_status,
  output logic              change,
  output logic              on_off,
  output logic [ID_W-1:0]   dev_id,
  output logic              busy
);

  logic [N_DEV-1:0] samp_q;
  logic [N_DEV-1:0] prev_q;
  logic [N_DEV-1:0] pend_q, pend_d;
  logic [N_DEV-1:0] dir_q, dir_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [ID_W-1:0]  dev_id_q, dev_id_d;
  logic             busy_q, busy_d;

  logic [N_DEV-1:0] lvl_s;
  logic [N_DEV-1:0] edge_s;
  logic             found_s;
  logic [ID_W-1:0]  gidx_s;

`ifdef DEBOUNCE_EN
  logic [N_DEV-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q [N_DEV];
  logic [7:0]       cnt_d [N_DEV];

  // A level is accepted only after the sample disagrees with it for DEB_CYCLES cycles in a row
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < N_DEV; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp_q[i] != acc_q[i]) begin
        if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
          acc_d[i] = samp_q[i];
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      for (int i = 0; i < N_DEV; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      acc_q <= acc_d;
      for (int i = 0; i < N_DEV; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign lvl_s = acc_q;
`else
  assign lvl_s = samp_q;
`endif

  assign edge_s = lvl_s ^ prev_q;

  // Round-robin search over pending devices, starting at the pointer
  always_comb begin
    int sum;
    logic [ID_W-1:0] idx;
    found_s = 1'b0;
    gidx_s  = '0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < N_DEV; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= N_DEV) begin
        sum = sum - N_DEV;
      end else begin
        sum = sum;
      end
      idx = ID_W'(sum);
      if (pend_q[idx] && !found_s) begin
        found_s = 1'b1;
        gidx_s  = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pending/direction update: a second edge before service cancels the first
  always_comb begin
    pend_d = pend_q;
    dir_d  = dir_q;
    for (int i = 0; i < N_DEV; i++) begin
      if (edge_s[i]) begin
        if (pend_q[i] && !(found_s && (gidx_s == ID_W'(i)))) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = 1'b1;
          dir_d[i]  = lvl_s[i];
        end
      end else if (found_s && (gidx_s == ID_W'(i))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Grant outputs and pointer advance
  always_comb begin
    change_d = found_s;
    busy_d   = |pend_d;
    if (found_s) begin
      on_off_d = dir_q[gidx_s];
      dev_id_d = gidx_s;
      if (gidx_s == ID_W'(N_DEV - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx_s + ID_W'(1);
      end
    end else begin
      on_off_d = 1'b0;
      dev_id_d = dev_id_q;
      ptr_d    = ptr_q;
    end
  end

  // Pipeline and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      dir_q    <= '0;
      ptr_q    <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      dev_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      samp_q   <= dev_status;
      prev_q   <= lvl_s;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      ptr_q    <= ptr_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      dev_id_q <= dev_id_d;
      busy_q   <= busy_d;
    end
  end

  assign change = change_q;
  assign on_off = on_off_q;
  assign dev_id = dev_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_iot_event_serializer.sv
// Scoreboard bench for iot_event_serializer (N_DEV=4): directed scenarios plus random traffic.
module tb_iot_event_serializer;
  localparam int N   = 4;
  localparam int DEB = 4;

  typedef struct packed {
    logic       change;
    logic       on_off;
    logic [1:0] dev_id;
    logic       busy;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] dev_status;
  logic         change;
  logic         on_off;
  logic [1:0]   dev_id;
  logic         busy;

  iot_event_serializer #(.N_DEV(N), .ID_W(2), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .dev_status(dev_status),
    .change(change), .on_off(on_off), .dev_id(dev_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int mon_count = 0;

  // Reference view: "seen" is the level the arbiter knows, "rep" is what the monitor was told.
  // A device has a pending event exactly when seen != rep; its direction is the seen level.
  logic [N-1:0] m_samp = '0;
  logic [N-1:0] m_seen = '0;
  logic [N-1:0] m_rep  = '0;
  logic [N-1:0] m_acc  = '0;
  int           m_run [N];
  int           m_ptr = 0;
  logic [1:0]   m_dev_id = 2'd0;

  task automatic model_step(input logic [N-1:0] d, input logic r);
    exp_t e;
    int g;
    bit found;
    if (r) begin
      m_samp = '0; m_seen = '0; m_rep = '0; m_acc = '0; m_ptr = 0; m_dev_id = 2'd0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      e = '0;
    end else begin
      found = 1'b0; g = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && (m_seen[i] != m_rep[i])) begin found = 1'b1; g = i; end
      end
      e = '0;
      if (found) begin
        e.change = 1'b1;
        e.on_off = m_seen[g];
        m_rep[g] = m_seen[g];
        m_dev_id = 2'(g);
        m_ptr    = (g + 1) % N;
      end
      e.dev_id = m_dev_id;
`ifdef DEBOUNCE_EN
      m_seen = m_acc;
      for (int i = 0; i < N; i++) begin
        if (m_samp[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_acc[i] = m_samp[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
`else
      m_seen = m_samp;
`endif
      m_samp = d;
      e.busy = |(m_seen ^ m_rep);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares each registered output tuple against the scoreboard and tracks the count
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({change, on_off, dev_id, busy} === e) begin
          n_pass++;
        end else begin
          $display("FAIL outputs t=%0t got chg=%b oo=%b id=%0d busy=%b want chg=%b oo=%b id=%0d busy=%b",
                   $time, change, on_off, dev_id, busy, e.change, e.on_off, e.dev_id, e.busy);
        end
      end
      if (rst) mon_count = 0;
      else if (change === 1'b1) mon_count = on_off ? mon_count + 1 : mon_count - 1;
    end
  end

  task automatic cyc(input logic [N-1:0] d, input logic r);
    @(negedge clk);
    dev_status = d;
    rst = r;
    model_step(d, r);
  endtask

  task automatic hold(input logic [N-1:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0);
  endtask

  task automatic do_reset(input logic [N-1:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b1);
  endtask

  task automatic check_count(input string name, input int want);
    @(negedge clk);
    n_checks++;
    if (mon_count == want) n_pass++;
    else $display("FAIL %s monitor count got %0d want %0d", name, mon_count, want);
  endtask

  initial begin
    logic [N-1:0] cur;
    rst = 1'b1;
    dev_status = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // 1: reset then quiet
    do_reset(4'b0000, 3);
    hold(4'b0000, 10);
    check_count("quiet", 0);

    // 2: single device on then off
    do_reset(4'b0000, 1);
    hold(4'b0001, 14);
    check_count("dev0_on", 1);
    hold(4'b0000, 14);
    check_count("dev0_off", 0);

    // 3: all on at once
    do_reset(4'b0000, 1);
    hold(4'b1111, 16);
    check_count("all_on", 4);

    // 4: dev3 glitch is cancelled
    do_reset(4'b0000, 1);
    cyc(4'b0111, 1'b0);
    cyc(4'b1111, 1'b0);
    hold(4'b0111, 16);
    check_count("cancel", 3);

    // 5: reset mid-burst
    do_reset(4'b0000, 1);
    hold(4'b1111, 4);
    cyc(4'b1111, 1'b1);
    hold(4'b1111, 16);
    check_count("mid_reset", 4);

`ifdef DEBOUNCE_EN
    // 6: short pulse filtered, held level accepted
    do_reset(4'b0000, 1);
    hold(4'b0001, 3);
    hold(4'b0000, 14);
    check_count("deb_glitch", 0);
    hold(4'b0001, 16);
    check_count("deb_hold", 1);
`endif

    // Random traffic with occasional resets
    do_reset(4'b0000, 1);
    cur = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ 4'($urandom_range(1, 15));
      cyc(cur, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    hold(cur, 20);
    check_count("random_settle", $countones(cur));

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain queue has %0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
